vga_line_buffer: RTL and testbench

//  Ping-pong line buffer that sits directly upstream of the VGA output pins.
//  A pixel producer streams 6-bit RRGGBB pixels in over a valid/ready handshake

---
 rtl/vga_pkg.sv | 7 +
 rtl/vga_line_ram.sv | 20 ++
 rtl/vga_line_buffer.sv | 92 +++++++++
 tb/tb_vga_line_buffer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA geometry, pixel width and line-buffer fill-state encoding
package vga_pkg;
    localparam int VISIBLE_X = 320;
    localparam int VISIBLE_Y = 480;
    localparam int CW = 6;
    typedef enum logic {FILLING = 1'b0, FULL = 1'b1} fill_state_t;
endpackage

// File: rtl/vga_line_ram.sv
// vga_line_ram: two-bank simple dual-port pixel RAM, bank chosen by address MSB
module vga_line_ram #(
    parameter int WIDTH = vga_pkg::VISIBLE_X,
    parameter int AW = 9,
    parameter int CW = vga_pkg::CW
) (
    input  logic          clk12,
    input  logic          we,
    input  logic [AW:0]   waddr,
    input  logic [CW-1:0] wdata,
    input  logic [AW:0]   raddr,
    output logic [CW-1:0] rdata
);
    logic [CW-1:0] mem [2][WIDTH];
    // synchronous write, registered read
    always_ff @(posedge clk12) begin
        if (we) mem[waddr[AW]][waddr[AW-1:0]] <= wdata;
        rdata <= mem[raddr[AW]][raddr[AW-1:0]];
    end
endmodule

// File: rtl/vga_line_buffer.sv
// vga_line_buffer: ping-pong line buffer feeding the VGA pins with aligned colour and syncs
module vga_line_buffer #(
    parameter int WIDTH = vga_pkg::VISIBLE_X,
    parameter int AW = 9,
    parameter int CW = vga_pkg::CW
) (
    input  logic          clk12,
    input  logic          rst_n,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [CW-1:0] wr_data,
    input  logic          de_in,
    input  logic          hsync_in,
    input  logic          vsync_in,
    input  logic          line_end,
    input  logic          frame_start,
    output logic [1:0]    red,
    output logic [1:0]    green,
    output logic [1:0]    blue,
    output logic          hsync,
    output logic          vsync,
    output logic          underrun
);
    import vga_pkg::*;
    localparam logic [AW-1:0] LAST = AW'(WIDTH - 1);
    localparam logic [AW-1:0] END_ADDR = AW'(WIDTH);
    fill_state_t state, state_n;
    logic [AW-1:0] wr_cnt, wr_cnt_n, rd_addr, rd_addr_n, rd_addr_d;
    logic fill_bank, disp_valid, de_d, accept, last, swap;
    logic [CW-1:0] rdata;
    assign wr_ready = state == FILLING;
    assign accept = wr_valid & wr_ready & ~frame_start;
    assign last = accept & (wr_cnt == LAST);
    assign swap = line_end & ~frame_start & ((state == FULL) | last);
    assign rd_addr_n = (line_end | frame_start) ? '0 : (de_in && rd_addr != END_ADDR) ? rd_addr + 1'b1 : rd_addr;
    assign {red, green, blue} = (de_d & disp_valid & (rd_addr_d < END_ADDR)) ? rdata : '0;
    // fill FSM next state: frame_start restarts, swap empties, accepted pixels advance
    always_comb begin
        state_n = state;
        wr_cnt_n = wr_cnt;
        if (frame_start) begin
            state_n = FILLING;
            wr_cnt_n = '0;
        end else if (swap) begin
            state_n = FILLING;
            wr_cnt_n = '0;
        end else if (accept) begin
            state_n = last ? FULL : FILLING;
            wr_cnt_n = wr_cnt + 1'b1;
        end
    end
    // fill FSM state register
    always_ff @(posedge clk12 or negedge rst_n) begin
        if (!rst_n) begin
            state <= FILLING;
            wr_cnt <= '0;
        end else begin
            state <= state_n;
            wr_cnt <= wr_cnt_n;
        end
    end
    // bank swap, read pointer and output pipeline aligned with the RAM read latency
    always_ff @(posedge clk12 or negedge rst_n) begin
        if (!rst_n) begin
            fill_bank <= 1'b0;
            disp_valid <= 1'b0;
            rd_addr <= '0;
            rd_addr_d <= '0;
            de_d <= 1'b0;
            hsync <= 1'b1;
            vsync <= 1'b1;
            underrun <= 1'b0;
        end else begin
            fill_bank <= fill_bank ^ swap;
            disp_valid <= disp_valid | swap;
            rd_addr <= rd_addr_n;
            rd_addr_d <= rd_addr;
            de_d <= de_in;
            hsync <= hsync_in;
            vsync <= vsync_in;
            underrun <= line_end & ~frame_start & ~swap;
        end
    end
    vga_line_ram #(.WIDTH(WIDTH), .AW(AW), .CW(CW)) u_ram (
        .clk12(clk12),
        .we(accept),
        .waddr({fill_bank, wr_cnt}),
        .wdata(wr_data),
        .raddr({~fill_bank, rd_addr}),
        .rdata(rdata)
    );
endmodule

// File: tb/tb_vga_line_buffer.sv
// tb_vga_line_buffer: directed self-checking bench for the ping-pong VGA line buffer
module tb_vga_line_buffer;
    logic clk12 = 1'b0;
    logic rst_n = 1'b1;
    logic wr_valid = 1'b0, de_in = 1'b0, hsync_in = 1'b1, vsync_in = 1'b1, line_end = 1'b0, frame_start = 1'b0;
    logic [5:0] wr_data = '0;
    logic wr_ready, hsync, vsync, underrun;
    logic [1:0] red, green, blue;
    logic [5:0] colour;
    int checks = 0;
    int failures = 0;

    typedef struct {
        logic hin, vin, bh, bv, ah, av;
    } sync_vec_t;

    assign colour = {red, green, blue};

    vga_line_buffer dut (
        .clk12(clk12), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .de_in(de_in), .hsync_in(hsync_in), .vsync_in(vsync_in), .line_end(line_end),
        .frame_start(frame_start), .red(red), .green(green), .blue(blue),
        .hsync(hsync), .vsync(vsync), .underrun(underrun)
    );

    always #5 clk12 = ~clk12;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk12);
        #1;
    endtask

    task automatic write_px(input int n, input int base, input bit fills);
        for (int i = 0; i < n; i++) begin
            wr_valid = 1'b1;
            wr_data = 6'((base + i) % 64);
            step();
            check($sformatf("wr_ready_after_write%0d", i), wr_ready, (fills && i == n - 1) ? 0 : 1);
        end
        wr_valid = 1'b0;
    endtask

    task automatic line_pulse();
        line_end = 1'b1;
        step();
        line_end = 1'b0;
    endtask

    task automatic frame_pulse();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        check("underrun_after_frame_start", underrun, 0);
    endtask

    task automatic show_line(input int len, input int base, input bit vis);
        for (int k = 0; k < len; k++) begin
            de_in = 1'b1;
            step();
            check($sformatf("colour_px%0d", k), colour, (vis && k < 320) ? (base + k) % 64 : 0);
        end
        de_in = 1'b0;
        step();
        check("colour_after_de", colour, 0);
    endtask

    initial begin
        sync_vec_t sv[6];
        sv[0] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        sv[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        sv[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        sv[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        sv[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        sv[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

        #2 rst_n = 1'b0;
        #1;
        check("reset_colour", colour, 0);
        check("reset_hsync", hsync, 1);
        check("reset_vsync", vsync, 1);
        check("reset_underrun", underrun, 0);
        check("reset_wr_ready", wr_ready, 1);
        step();
        step();
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 6; i++) begin
            hsync_in = sv[i].hin;
            vsync_in = sv[i].vin;
            #2;
            check($sformatf("sync_before_h%0d", i), hsync, sv[i].bh);
            check($sformatf("sync_before_v%0d", i), vsync, sv[i].bv);
            @(posedge clk12);
            #1;
            check($sformatf("sync_after_h%0d", i), hsync, sv[i].ah);
            check($sformatf("sync_after_v%0d", i), vsync, sv[i].av);
        end
        hsync_in = 1'b1;
        vsync_in = 1'b1;

        write_px(320, 0, 1'b1);
        wr_valid = 1'b1;
        wr_data = 6'd63;
        step();
        wr_valid = 1'b0;
        check("wr_ready_held_full", wr_ready, 0);
        line_pulse();
        check("t1_underrun", underrun, 0);
        check("t1_wr_ready_after_swap", wr_ready, 1);
        show_line(320, 0, 1'b1);

        write_px(100, 10, 1'b0);
        line_pulse();
        check("t2_underrun_pulse", underrun, 1);
        step();
        check("t2_underrun_cleared", underrun, 0);
        show_line(320, 0, 1'b1);
        write_px(220, 110, 1'b1);
        line_pulse();
        check("t2_underrun_on_swap", underrun, 0);
        show_line(320, 10, 1'b1);

        write_px(319, 20, 1'b0);
        wr_valid = 1'b1;
        wr_data = 6'd19;
        line_end = 1'b1;
        step();
        wr_valid = 1'b0;
        line_end = 1'b0;
        check("t3_underrun", underrun, 0);
        check("t3_wr_ready", wr_ready, 1);
        show_line(320, 20, 1'b1);

        write_px(150, 30, 1'b0);
        frame_start = 1'b1;
        line_end = 1'b1;
        wr_valid = 1'b1;
        wr_data = 6'd63;
        step();
        frame_start = 1'b0;
        line_end = 1'b0;
        wr_valid = 1'b0;
        check("t4_underrun", underrun, 0);
        check("t4_wr_ready", wr_ready, 1);
        show_line(320, 20, 1'b1);
        write_px(320, 40, 1'b1);
        line_pulse();
        check("t4_underrun_on_swap", underrun, 0);
        show_line(320, 40, 1'b1);

        frame_pulse();
        show_line(330, 40, 1'b1);

        frame_pulse();
        hsync_in = 1'b0;
        vsync_in = 1'b0;
        for (int k = 0; k < 50; k++) begin
            de_in = 1'b1;
            step();
            check($sformatf("t6_colour_px%0d", k), colour, (40 + k) % 64);
        end
        check("t6_hsync_low", hsync, 0);
        check("t6_vsync_low", vsync, 0);
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_colour", colour, 0);
        check("t6_async_hsync", hsync, 1);
        check("t6_async_vsync", vsync, 1);
        check("t6_async_wr_ready", wr_ready, 1);
        de_in = 1'b0;
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        step();
        step();
        rst_n = 1'b1;
        step();
        show_line(320, 0, 1'b0);
        write_px(320, 50, 1'b1);
        line_pulse();
        check("t6_underrun_on_swap", underrun, 0);
        show_line(320, 50, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
